// File: rtl/parallel_to_serial.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a
// ready/load handshake and shifts it out one bit per clock, with valid and
// last-bit framing strobes. Back-to-back words stream with no idle gap.
module parallel_to_serial #(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic [WIDTH-1:0] pinIn,
  input  logic             loadIn,
  output logic             readyOut,
  output logic             serOut,
  output logic             validOut,
  output logic             lastOut,
  output logic             busyOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             at_last;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign at_last = (state == SHIFT) && (cnt == LAST_CNT);
  assign accept  = loadIn && readyOut;
  // The output end is bit 0 for LSB-first and bit WIDTH-1 for MSB-first.
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg[WIDTH-1:1]};

  // State, shift register and bit counter; reset wins over any load.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: load from IDLE or during the last-bit cycle, else shift.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_nxt = pinIn;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          shreg_nxt = pinIn;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end else if (at_last) begin
          shreg_nxt = shifted;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          shreg_nxt = shifted;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state; no path from loadIn/pinIn.
  always_comb begin
    readyOut = 1'b0;
    serOut   = IDLE_LEVEL;
    validOut = 1'b0;
    lastOut  = 1'b0;
    busyOut  = 1'b0;
    if (state == SHIFT) begin
      serOut   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      validOut = 1'b1;
      busyOut  = 1'b1;
      lastOut  = at_last;
      readyOut = at_last;
    end else begin
      readyOut = 1'b1;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: an LSB-first instance (idle level 0) and an
// MSB-first instance (idle level 1) checked every cycle against a queue model
// of the bits still to be sent, plus directed word and loopback checks.
module tb_parallel_to_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       load0, load1;
  logic [3:0] pin0, pin1;
  logic       ready0, ser0, valid0, last0, busy0;
  logic       ready1, ser1, valid1, last1, busy1;

  int unsigned tests = 0;
  int unsigned fails = 0;

  bit   q0[$];
  bit   q1[$];
  bit   cap0[$];
  bit   cap1[$];
  logic [3:0] rx;

  always #5 clk = ~clk;

  parallel_to_serial #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
    .clkIn(clk), .rstIn(rst), .pinIn(pin0), .loadIn(load0),
    .readyOut(ready0), .serOut(ser0), .validOut(valid0),
    .lastOut(last0), .busyOut(busy0)
  );

  parallel_to_serial #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
    .clkIn(clk), .rstIn(rst), .pinIn(pin1), .loadIn(load1),
    .readyOut(ready1), .serOut(ser1), .validOut(valid1),
    .lastOut(last1), .busyOut(busy1)
  );

  // 4-bit receiver: shifts right, inserting each valid bit at the MSB.
  always @(posedge clk) begin
    if (valid0) rx <= {ser0, rx[3:1]};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack(input bit q[$]);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < 8; i++) v[i] = q[i];
    return v;
  endfunction

  // Model: a word in flight is the queue of its unsent bits in send order.
  task automatic check_all();
    chk("valid0", {7'd0, valid0}, {7'd0, q0.size() > 0});
    chk("busy0",  {7'd0, busy0},  {7'd0, q0.size() > 0});
    chk("last0",  {7'd0, last0},  {7'd0, q0.size() == 1});
    chk("ready0", {7'd0, ready0}, {7'd0, q0.size() <= 1});
    chk("ser0",   {7'd0, ser0},   {7'd0, (q0.size() > 0) ? q0[0] : 1'b0});
    chk("valid1", {7'd0, valid1}, {7'd0, q1.size() > 0});
    chk("busy1",  {7'd0, busy1},  {7'd0, q1.size() > 0});
    chk("last1",  {7'd0, last1},  {7'd0, q1.size() == 1});
    chk("ready1", {7'd0, ready1}, {7'd0, q1.size() <= 1});
    chk("ser1",   {7'd0, ser1},   {7'd0, (q1.size() > 0) ? q1[0] : 1'b1});
  endtask

  task automatic tick();
    bit rdy0, rdy1;
    rdy0 = (q0.size() <= 1);
    rdy1 = (q1.size() <= 1);
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (load0 && rdy0) for (int i = 0; i < 4; i++) q0.push_back(pin0[i]);
      if (load1 && rdy1) for (int i = 0; i < 4; i++) q1.push_back(pin1[3-i]);
    end
    #1;
    check_all();
    if (valid0) cap0.push_back(ser0);
    if (valid1) cap1.push_back(ser1);
  endtask

  initial begin
    rst = 1'b1; load0 = 1'b0; load1 = 1'b0; pin0 = '0; pin1 = '0; rx = '0;

    // Reset held two cycles, then released.
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_ready0", {7'd0, ready0}, 8'd1);
    chk("reset_ser1_idle", {7'd0, ser1}, 8'd1);

    // 4'b1011 into both: LSB-first 1,1,0,1 and MSB-first 1,0,1,1.
    cap0.delete(); cap1.delete();
    pin0 = 4'b1011; pin1 = 4'b1011; load0 = 1'b1; load1 = 1'b1;
    tick();
    load0 = 1'b0; load1 = 1'b0; pin0 = 4'b0000; pin1 = 4'b0000;
    repeat (5) tick();
    chk("lsb_word_1011", {4'd0, pack(cap0)} & 8'hFF, 8'b0000_1011);
    chk("lsb_word_len", 8'(cap0.size()), 8'd4);
    chk("msb_word_1011", pack(cap1), 8'b0000_1101);
    chk("msb_word_len", 8'(cap1.size()), 8'd4);

    // Load 0110, then hold load with 1001: second word taken at last bit.
    cap0.delete();
    pin0 = 4'b0110; load0 = 1'b1;
    tick();
    pin0 = 4'b1001;
    repeat (4) tick();
    load0 = 1'b0; pin0 = 4'b1111;
    repeat (5) tick();
    chk("b2b_stream", pack(cap0), 8'b1001_0110);
    chk("b2b_len", 8'(cap0.size()), 8'd8);

    // Reset after two bits of 1111 aborts the word; 0001 then sends 1,0,0,0.
    pin0 = 4'b1111; load0 = 1'b1;
    tick();
    load0 = 1'b0;
    tick();
    rst = 1'b1; load0 = 1'b1; pin0 = 4'b0101;
    tick();
    chk("abort_valid0", {7'd0, valid0}, 8'd0);
    chk("abort_ready0", {7'd0, ready0}, 8'd1);
    rst = 1'b0; load0 = 1'b0;
    cap0.delete();
    pin0 = 4'b0001; load0 = 1'b1;
    tick();
    load0 = 1'b0;
    repeat (5) tick();
    chk("after_abort_word", pack(cap0), 8'b0000_0001);
    chk("after_abort_len", 8'(cap0.size()), 8'd4);

    // Loopback into the 4-bit receiver.
    rx = 4'b0000;
    pin0 = 4'b1010; load0 = 1'b1;
    tick();
    load0 = 1'b0;
    repeat (4) tick();
    chk("loopback_rx", {4'd0, rx}, 8'b0000_1010);
    tick();

    // Randomized loads, data and occasional resets.
    for (int n = 0; n < 400; n++) begin
      load0 = ($urandom_range(0, 2) != 0);
      load1 = ($urandom_range(0, 1) != 0);
      pin0  = 4'($urandom);
      pin1  = 4'($urandom);
      rst   = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0; load0 = 1'b0; load1 = 1'b0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
